uart_tx_retry: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_retry_if.sv | 23 ++
 rtl/uart_tx_shifter.sv | 35 +++
 rtl/uart_tx_retry.sv | 148 ++++++++++++++
 tb/tb_uart_tx_retry.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings and frame constants
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } tx_state_t;

    localparam int   UART_SIZE   = 32;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_retry_if.sv
// rtl/uart_tx_retry_if.sv - load/serial/retry handshake bundle for the transmitter
interface uart_tx_retry_if #(parameter int size = 32);

    logic [size-1:0] DataIn;
    logic            LoadTx;
    logic            ReadyTx;
    logic            SerialOutData;
    logic            DoneTx;
    logic            Flag_Rx;
    logic            RetryErr;
    logic            BusyTx;

    modport master (
        output DataIn, LoadTx, Flag_Rx,
        input  ReadyTx, SerialOutData, DoneTx, RetryErr, BusyTx
    );

    modport slave (
        input  DataIn, LoadTx, Flag_Rx,
        output ReadyTx, SerialOutData, DoneTx, RetryErr, BusyTx
    );

endinterface

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - parallel-load right shifter with shifted-bit counter
module uart_tx_shifter #(
    parameter int size = 32
) (
    input  logic            CLK_Baudin,
    input  logic            RstRx,
    input  logic            i_load,
    input  logic [size-1:0] i_data,
    input  logic            i_shift,
    output logic            o_bit,
    output logic            o_done
);

    localparam int CW = $clog2(size + 1);

    logic [size-1:0] r_sr;
    logic [CW-1:0]   r_cnt;

    always_ff @(posedge CLK_Baudin or posedge RstRx) begin
        if (RstRx) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= r_sr >> 1;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_bit  = r_sr[0];
    assign o_done = (r_cnt == CW'(size));

endmodule

// File: rtl/uart_tx_retry.sv
// rtl/uart_tx_retry.sv - framed UART transmitter holding each word for bounded retransmission
module uart_tx_retry
    import uart_pkg::*;
#(
    parameter int size       = UART_SIZE,
    parameter int MAX_RETRY  = 3,
    parameter int PARITY_ODD = 0
) (
    input  logic           CLK_Baudin,
    input  logic           RstRx,
    uart_tx_retry_if.slave tx
);

    localparam int   RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : PARITY_EVEN;

    tx_state_t       r_state, w_next_state;
    logic            r_line, w_line;
    logic            r_ready, w_ready;
    logic            r_busy;
    logic            r_done, w_done;
    logic            r_err, w_err;
    logic            r_parity, w_parity;
    logic [size-1:0] r_word, w_word;
    logic [RW-1:0]   r_retry, w_retry;
    logic            r_retry_req, w_retry_req;
    logic            w_load, w_shift, w_bit, w_sh_done;
    logic [size-1:0] w_load_data;

    uart_tx_shifter #(.size(size)) u_shifter (
        .CLK_Baudin (CLK_Baudin),
        .RstRx      (RstRx),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_shift    (w_shift),
        .o_bit      (w_bit),
        .o_done     (w_sh_done)
    );

    always_ff @(posedge CLK_Baudin or posedge RstRx) begin
        if (RstRx) begin
            r_state     <= S_IDLE;
            r_line      <= IDLE_LEVEL;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_parity    <= 1'b0;
            r_word      <= '0;
            r_retry     <= '0;
            r_retry_req <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_line      <= w_line;
            r_ready     <= w_ready;
            r_busy      <= ~w_ready;
            r_done      <= w_done;
            r_err       <= w_err;
            r_parity    <= w_parity;
            r_word      <= w_word;
            r_retry     <= w_retry;
            r_retry_req <= w_retry_req;
        end
    end

    // Each state computes the line level to hold during the following cycle.
    always_comb begin
        w_next_state = r_state;
        w_line       = r_line;
        w_ready      = r_ready;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_parity     = r_parity;
        w_word       = r_word;
        w_retry      = r_retry;
        w_retry_req  = r_retry_req;
        w_load       = 1'b0;
        w_load_data  = r_word;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_line  = IDLE_LEVEL;
                w_ready = 1'b1;
                if (tx.LoadTx && r_ready) begin
                    w_word       = tx.DataIn;
                    w_parity     = ^tx.DataIn ^ PAR_MODE;
                    w_retry      = '0;
                    w_ready      = 1'b0;
                    w_load       = 1'b1;
                    w_load_data  = tx.DataIn;
                    w_line       = START_BIT;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_line       = w_bit;
                w_shift      = 1'b1;
                w_next_state = S_DATA;
            end
            S_DATA: begin
                if (w_sh_done) begin
                    w_line       = r_parity;
                    w_next_state = S_PARITY;
                end else begin
                    w_line  = w_bit;
                    w_shift = 1'b1;
                end
            end
            S_PARITY: begin
                w_line       = STOP_BIT;
                w_next_state = S_STOP;
            end
            S_STOP: begin
                w_line       = STOP_BIT;
                w_done       = 1'b1;
                w_next_state = S_GAP;
                if (tx.Flag_Rx)
                    w_retry_req = 1'b1;
            end
            S_GAP: begin
                w_retry_req = 1'b0;
                if ((r_retry_req || tx.Flag_Rx) && (r_retry < RW'(MAX_RETRY))) begin
                    w_retry      = r_retry + RW'(1);
                    w_load       = 1'b1;
                    w_line       = START_BIT;
                    w_next_state = S_START;
                end else begin
                    w_err        = r_retry_req || tx.Flag_Rx;
                    w_ready      = 1'b1;
                    w_line       = IDLE_LEVEL;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_line       = IDLE_LEVEL;
                w_ready      = 1'b1;
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign tx.SerialOutData = r_line;
    assign tx.ReadyTx       = r_ready;
    assign tx.BusyTx        = r_busy;
    assign tx.DoneTx        = r_done;
    assign tx.RetryErr      = r_err;

endmodule

// File: tb/tb_uart_tx_retry.sv
// tb/tb_uart_tx_retry.sv - directed self-checking bench for uart_tx_retry
module tb_uart_tx_retry;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic cap_line  [0:159];
    logic cap_done  [0:159];
    logic cap_ready [0:159];
    logic cap_err   [0:159];

    uart_tx_retry_if #(.size(32)) bus ();
    uart_tx_retry_if #(.size(32)) bus_o ();

    uart_tx_retry #(.size(32), .MAX_RETRY(3), .PARITY_ODD(0)) dut (
        .CLK_Baudin (clk),
        .RstRx      (rst),
        .tx         (bus)
    );

    uart_tx_retry #(.size(32), .MAX_RETRY(0), .PARITY_ODD(1)) dut_odd (
        .CLK_Baudin (clk),
        .RstRx      (rst),
        .tx         (bus_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [31:0] d, input logic p, input int c);
        if (c == 0)       return 1'b0;
        else if (c <= 32) return d[c-1];
        else if (c == 33) return p;
        else              return 1'b1;
    endfunction

    function automatic int count_frames(input int n, output logic [31:0] d0, output logic ok0);
        int c = 0;
        int f = 0;
        d0  = '0;
        ok0 = 1'b0;
        while (c < n) begin
            logic [31:0] d;
            if (cap_line[c] === 1'b0) begin
                if (c + 34 < n) begin
                    for (int i = 0; i < 32; i++) d[i] = cap_line[c+1+i];
                    if (f == 0) begin
                        d0  = d;
                        ok0 = (cap_line[c+33] === ^d) && (cap_line[c+34] === 1'b1);
                    end
                end
                f++;
                c += 35;
            end else begin
                c++;
            end
        end
        return f;
    endfunction

    task automatic start_word(input logic [31:0] d);
        bus.DataIn = d;
        bus.LoadTx = 1'b1;
        tick();
        bus.LoadTx = 1'b0;
    endtask

    task automatic capture(input int n, input int flag_from, input int flag_to,
                           input int load_at, input logic [31:0] load_d);
        for (int c = 0; c < n; c++) begin
            if (c > 0) tick();
            cap_line[c]  = bus.SerialOutData;
            cap_done[c]  = bus.DoneTx;
            cap_ready[c] = bus.ReadyTx;
            cap_err[c]   = bus.RetryErr;
            bus.Flag_Rx  = (c >= flag_from) && (c <= flag_to);
            bus.LoadTx   = (c == load_at);
            if (c == load_at) bus.DataIn = load_d;
        end
        bus.Flag_Rx = 1'b0;
        bus.LoadTx  = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.SerialOutData, bus.ReadyTx, bus.BusyTx, bus.DoneTx, bus.RetryErr} !== 5'b11000) begin
            $display("FAIL reset_outputs got %b want 11000",
                     {bus.SerialOutData, bus.ReadyTx, bus.BusyTx, bus.DoneTx, bus.RetryErr});
        end else n_pass++;
    endtask

    task automatic test_basic_frame();
        int bad_line = 0, bad_done = 0, bad_ready = 0, bad_err = 0;
        start_word(32'hA5A5_0F0F);
        capture(37, -1, -1, -1, 32'h0);
        for (int c = 0; c < 36; c++) begin
            if (cap_line[c] !== exp_bit(32'hA5A5_0F0F, 1'b0, c)) bad_line++;
            if (cap_done[c] !== (c == 35)) bad_done++;
            if (cap_ready[c] !== 1'b0) bad_ready++;
            if (cap_err[c] !== 1'b0) bad_err++;
        end
        n_checks++;
        if (bad_line != 0) $display("FAIL basic_line bad_bits=%0d want 0", bad_line); else n_pass++;
        n_checks++;
        if (bad_done != 0) $display("FAIL basic_done_pulse bad_cycles=%0d want 0", bad_done); else n_pass++;
        n_checks++;
        if (bad_ready != 0 || cap_ready[36] !== 1'b1 || cap_done[36] !== 1'b0)
            $display("FAIL basic_ready bad=%0d ready36=%b done36=%b want 0/1/0", bad_ready, cap_ready[36], cap_done[36]);
        else n_pass++;
        n_checks++;
        if (bad_err != 0 || bus.BusyTx !== 1'b0)
            $display("FAIL basic_err_busy err_cycles=%0d busy=%b want 0/0", bad_err, bus.BusyTx);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [31:0] rx_data;
        logic        rx_ok;
        int          frames, dones = 0;
        start_word(32'hDEAD_BEEF);
        capture(80, -1, -1, -1, 32'h0);
        frames = count_frames(80, rx_data, rx_ok);
        for (int c = 0; c < 80; c++) if (cap_done[c] === 1'b1) dones++;
        n_checks++;
        if (rx_data !== 32'hDEAD_BEEF || rx_ok !== 1'b1)
            $display("FAIL loopback_data got %h ok=%b want deadbeef ok=1", rx_data, rx_ok);
        else n_pass++;
        n_checks++;
        if (frames != 1 || dones != 1)
            $display("FAIL loopback_frames frames=%0d dones=%0d want 1/1", frames, dones);
        else n_pass++;
    endtask

    task automatic test_retry_once();
        int bad_line = 0, bad_done = 0, bad_ready = 0;
        start_word(32'h0000_0007);
        capture(73, 34, 34, -1, 32'h0);
        for (int c = 0; c < 72; c++) begin
            if (cap_line[c] !== exp_bit(32'h0000_0007, 1'b1, c % 36)) bad_line++;
            if (cap_done[c] !== (c == 35 || c == 71)) bad_done++;
            if (cap_ready[c] !== 1'b0) bad_ready++;
        end
        n_checks++;
        if (bad_line != 0) $display("FAIL retry_once_line bad_bits=%0d want 0", bad_line); else n_pass++;
        n_checks++;
        if (bad_done != 0) $display("FAIL retry_once_done bad_cycles=%0d want 0", bad_done); else n_pass++;
        n_checks++;
        if (bad_ready != 0 || cap_ready[72] !== 1'b1 || cap_err[72] !== 1'b0)
            $display("FAIL retry_once_ready bad=%0d ready72=%b err72=%b want 0/1/0", bad_ready, cap_ready[72], cap_err[72]);
        else n_pass++;
    endtask

    task automatic test_retry_max();
        logic [31:0] d0;
        logic        ok0;
        int          frames, bad_line = 0, bad_done = 0, bad_err = 0;
        start_word(32'h0000_00C3);
        capture(150, 0, 149, -1, 32'h0);
        frames = count_frames(150, d0, ok0);
        for (int c = 0; c < 150; c++) begin
            if (c < 144 && cap_line[c] !== exp_bit(32'h0000_00C3, 1'b0, c % 36)) bad_line++;
            if (cap_done[c] !== (c < 144 && (c % 36) == 35)) bad_done++;
            if (cap_err[c] !== (c == 144)) bad_err++;
        end
        n_checks++;
        if (frames != 4 || bad_line != 0)
            $display("FAIL retry_max_frames frames=%0d bad_bits=%0d want 4/0", frames, bad_line);
        else n_pass++;
        n_checks++;
        if (bad_done != 0 || bad_err != 0)
            $display("FAIL retry_max_pulses bad_done=%0d bad_err=%0d want 0/0", bad_done, bad_err);
        else n_pass++;
        n_checks++;
        if (cap_ready[143] !== 1'b0 || cap_ready[144] !== 1'b1)
            $display("FAIL retry_max_ready r143=%b r144=%b want 0/1", cap_ready[143], cap_ready[144]);
        else n_pass++;
        bad_line = 0;
        bad_err  = 0;
        start_word(32'h0000_0001);
        capture(37, -1, -1, -1, 32'h0);
        for (int c = 0; c < 37; c++) begin
            if (c < 36 && cap_line[c] !== exp_bit(32'h0000_0001, 1'b1, c)) bad_line++;
            if (cap_err[c] !== 1'b0) bad_err++;
        end
        n_checks++;
        if (bad_line != 0 || bad_err != 0 || cap_ready[36] !== 1'b1)
            $display("FAIL after_retry_err_send bad_bits=%0d err=%0d ready=%b want 0/0/1", bad_line, bad_err, cap_ready[36]);
        else n_pass++;
    endtask

    task automatic test_busy_load();
        int bad_line = 0, bad_done = 0;
        start_word(32'hFFFF_0000);
        capture(41, -1, -1, 10, 32'h1234_5678);
        for (int c = 0; c < 41; c++) begin
            if (cap_line[c] !== exp_bit(32'hFFFF_0000, 1'b0, (c > 35) ? 35 : c)) bad_line++;
            if (cap_done[c] !== (c == 35)) bad_done++;
        end
        n_checks++;
        if (bad_line != 0 || bad_done != 0)
            $display("FAIL busy_load_ignored bad_bits=%0d bad_done=%0d want 0/0", bad_line, bad_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        start_word(32'hFFFF_0000);
        for (int c = 0; c < 8; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.SerialOutData, bus.ReadyTx, bus.BusyTx} !== 3'b110)
            $display("FAIL reset_mid_async got %b want 110", {bus.SerialOutData, bus.ReadyTx, bus.BusyTx});
        else n_pass++;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.DoneTx !== 1'b0 || bus.SerialOutData !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL reset_mid_quiet bad_cycles=%0d want 0", bad); else n_pass++;
    endtask

    task automatic odd_parity_bit(input logic [31:0] d, input logic want, input string name);
        bus_o.DataIn = d;
        bus_o.LoadTx = 1'b1;
        tick();
        bus_o.LoadTx = 1'b0;
        for (int c = 0; c < 33; c++) tick();
        n_checks++;
        if (bus_o.SerialOutData !== want)
            $display("FAIL %s got %b want %b", name, bus_o.SerialOutData, want);
        else n_pass++;
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_odd_and_no_retry();
        odd_parity_bit(32'h0000_0001, 1'b0, "odd_parity_one");
        odd_parity_bit(32'h0000_0000, 1'b1, "odd_parity_zero");
        bus_o.DataIn  = 32'h0000_0003;
        bus_o.LoadTx  = 1'b1;
        tick();
        bus_o.LoadTx  = 1'b0;
        bus_o.Flag_Rx = 1'b1;
        for (int c = 0; c < 36; c++) tick();
        n_checks++;
        if ({bus_o.RetryErr, bus_o.ReadyTx, bus_o.SerialOutData} !== 3'b111)
            $display("FAIL no_retry_err got %b want 111", {bus_o.RetryErr, bus_o.ReadyTx, bus_o.SerialOutData});
        else n_pass++;
        tick();
        n_checks++;
        if (bus_o.RetryErr !== 1'b0)
            $display("FAIL no_retry_err_width got %b want 0", bus_o.RetryErr);
        else n_pass++;
        bus_o.Flag_Rx = 1'b0;
        tick();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_checks = 0;
        n_pass   = 0;
        bus.DataIn    = '0;
        bus.LoadTx    = 1'b0;
        bus.Flag_Rx   = 1'b0;
        bus_o.DataIn  = '0;
        bus_o.LoadTx  = 1'b0;
        bus_o.Flag_Rx = 1'b0;
        #2;
        test_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_basic_frame();
        tick();
        test_loopback();
        tick();
        test_retry_once();
        tick();
        test_retry_max();
        tick();
        test_busy_load();
        tick();
        test_reset_mid();
        test_odd_and_no_retry();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
